fb_line_fetch: RTL and testbench

Reads a framebuffer row by row and streams each row into the display linebuffer. It runs in the system clock domain, takes the frame and line flags after they cross from the pixel domain, and drives the framebuffer BRAM read port. It is the read-side counterpart of the render/bitmap_addr write path. It replaces hand-written read counters in top-level demos and adds scaling, latency alignment and overrun detection.

---
 rtl/fb_pkg.sv | 13 +
 rtl/sr_delay.sv | 28 ++
 rtl/fb_line_fetch.sv | 178 +++++++++++++++++
 tb/tb_fb_line_fetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Framebuffer geometry defaults and helpers
// shared by the display read path.
package fb_pkg;

  localparam int FB_W_DEF     = 320;
  localparam int FB_H_DEF     = 180;
  localparam int FB_SCALE_DEF = 2;

  function automatic int fb_addr_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/sr_delay.sv
// Single-bit delay line with synchronous reset
// and a flush input that empties every stage.
module sr_delay #(
  parameter int LEN = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic d,
  output logic q
);

  logic [LEN-1:0] sr;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      sr <= '0;
    end else begin
      sr[0] <= d;
      for (int i = 1; i < LEN; i++) begin
        sr[i] <= sr[i-1];
      end
    end
  end

  assign q = sr[LEN-1];

endmodule

// File: rtl/fb_line_fetch.sv
// Streams framebuffer rows into the display
// linebuffer with line scaling and overrun abort.
module fb_line_fetch
  import fb_pkg::*;
#(
  parameter int FB_WIDTH = FB_W_DEF,
  parameter int FB_HEIGHT = FB_H_DEF,
  parameter int FB_SCALE = FB_SCALE_DEF,
  parameter int ADDRW = fb_addr_w(FB_WIDTH, FB_HEIGHT),
  parameter int DATAW = 4,
  parameter int LAT_MEM = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame,
  input  logic             line0,
  input  logic             line,
  output logic [ADDRW-1:0] fb_addr,
  output logic             fb_re,
  input  logic [DATAW-1:0] fb_data,
  output logic             lb_en,
  output logic [DATAW-1:0] lb_data,
  output logic             busy,
  output logic             done,
  output logic             overrun
);

  localparam int XW = $clog2(FB_WIDTH + 1);
  localparam int RW = $clog2(FB_HEIGHT + 1);
  localparam int DW = $clog2(LAT_MEM + 1) + 1;
  localparam int SW = 6;

  localparam logic [XW-1:0] X_END = XW'(FB_WIDTH);
  localparam logic [RW-1:0] ROW_LAST = RW'(FB_HEIGHT - 1);
  localparam logic [SW-1:0] SC_LAST = SW'(FB_SCALE - 1);
  localparam logic [DW-1:0] D_LAST = DW'(LAT_MEM);
  localparam logic [ADDRW-1:0] STRIDE = ADDRW'(FB_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_WAIT,
    S_FETCH,
    S_DRAIN
  } state_t;

  state_t state, state_d;

  logic [XW-1:0] cnt_x;
  logic [RW-1:0] row;
  logic [SW-1:0] cnt_scale, cs_d, cs_inc;
  logic [DW-1:0] cnt_d;
  logic [ADDRW-1:0] row_base, rb_next;

  logic start, adv, ovr, fin, flush, arm, last_row;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d  = state;
    start    = 1'b0;
    adv      = 1'b0;
    ovr      = 1'b0;
    fin      = 1'b0;
    flush    = 1'b0;
    arm      = 1'b0;
    cs_d     = cnt_scale;
    last_row = (row == ROW_LAST);
    cs_inc   = (cnt_scale == SC_LAST) ? '0 : cnt_scale + 1'b1;
    if (frame) begin
      state_d = S_ARMED;
      arm     = 1'b1;
      flush   = 1'b1;
      cs_d    = '0;
    end else begin
      unique case (state)
        S_IDLE: ;
        S_ARMED: begin
          if (line0) begin
            state_d = S_FETCH;
            start   = 1'b1;
            cs_d    = '0;
          end
        end
        S_WAIT: begin
          if (line) begin
            cs_d = cs_inc;
            if (cs_inc == '0) begin
              state_d = S_FETCH;
              start   = 1'b1;
            end
          end
        end
        S_FETCH, S_DRAIN: begin
          if (line) begin
            // Late row: give it up but keep the image aligned.
            ovr   = 1'b1;
            flush = 1'b1;
            if (last_row) begin
              fin     = 1'b1;
              state_d = S_IDLE;
            end else begin
              adv  = 1'b1;
              cs_d = cs_inc;
              if (cs_inc == '0) begin
                state_d = S_FETCH;
                start   = 1'b1;
              end else begin
                state_d = S_WAIT;
              end
            end
          end else if (state == S_FETCH) begin
            if (cnt_x == X_END) state_d = S_DRAIN;
          end else if (cnt_d == D_LAST) begin
            fin     = last_row;
            adv     = !last_row;
            state_d = last_row ? S_IDLE : S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign rb_next = adv ? row_base + STRIDE : row_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      row       <= '0;
      row_base  <= '0;
      cnt_scale <= '0;
      cnt_x     <= '0;
      cnt_d     <= '0;
      fb_addr   <= '0;
      fb_re     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      lb_data   <= '0;
    end else begin
      if (arm) begin
        row      <= '0;
        row_base <= '0;
      end else if (adv) begin
        row      <= row + 1'b1;
        row_base <= rb_next;
      end
      cnt_scale <= cs_d;
      if (start) begin
        fb_addr <= rb_next;
        cnt_x   <= XW'(1);
      end else if (state_d == S_FETCH) begin
        fb_addr <= row_base + ADDRW'(cnt_x);
        cnt_x   <= cnt_x + 1'b1;
      end
      cnt_d   <= (state == S_DRAIN) ? cnt_d + 1'b1 : '0;
      fb_re   <= (state_d == S_FETCH);
      busy    <= (state_d != S_IDLE);
      done    <= fin;
      overrun <= ovr;
      lb_data <= fb_data;
    end
  end

  sr_delay #(
    .LEN(LAT_MEM + 1)
  ) u_en_dly (
    .clk(clk),
    .rst(rst),
    .clr(flush),
    .d  (fb_re),
    .q  (lb_en)
  );

endmodule

// File: tb/tb_fb_line_fetch.sv
// Directed bench for fb_line_fetch with a
// BRAM model whose contents equal the address.
module tb_fb_line_fetch;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame = 1'b0;
  logic line0 = 1'b0;
  logic line = 1'b0;
  logic [3:0] fb_addr;
  logic [3:0] fb_data = '0;
  logic [3:0] lb_data;
  logic fb_re, lb_en, busy, done, overrun;

  always #5 clk = ~clk;

  fb_line_fetch #(
    .FB_WIDTH (4),
    .FB_HEIGHT(3),
    .FB_SCALE (2),
    .ADDRW    (4),
    .DATAW    (4),
    .LAT_MEM  (1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .frame  (frame),
    .line0  (line0),
    .line   (line),
    .fb_addr(fb_addr),
    .fb_re  (fb_re),
    .fb_data(fb_data),
    .lb_en  (lb_en),
    .lb_data(lb_data),
    .busy   (busy),
    .done   (done),
    .overrun(overrun)
  );

  always @(posedge clk) if (fb_re) fb_data <= fb_addr;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0] lbq[$];
  logic [3:0] rise_addr[$];
  int rise_cyc[$];
  int last_en = 0, done_n = 0, done_at = 0, ovr_n = 0, re_n = 0;
  logic re_prev = 1'b0;

  always @(negedge clk) begin
    if (lb_en) begin
      lbq.push_back(lb_data);
      last_en = cyc;
    end
    if (done) begin
      done_n++;
      done_at = cyc;
    end
    if (overrun) ovr_n++;
    if (fb_re) re_n++;
    if (fb_re && !re_prev) begin
      rise_cyc.push_back(cyc);
      rise_addr.push_back(fb_addr);
    end
    re_prev = fb_re;
  end

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step(input logic f, input logic l0, input logic l);
    frame = f;
    line0 = l0;
    line  = l;
    @(posedge clk);
    #1;
    frame = 1'b0;
    line0 = 1'b0;
    line  = 1'b0;
  endtask

  task automatic clr_log();
    lbq.delete();
    rise_cyc.delete();
    rise_addr.delete();
    done_n = 0;
    ovr_n  = 0;
    re_n   = 0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " fb_addr"}, 32'(fb_addr), 0);
    chk({tag, " fb_re"}, 32'(fb_re), 0);
    chk({tag, " lb_en"}, 32'(lb_en), 0);
    chk({tag, " lb_data"}, 32'(lb_data), 0);
    chk({tag, " busy"}, 32'(busy), 0);
    chk({tag, " done"}, 32'(done), 0);
    chk({tag, " overrun"}, 32'(overrun), 0);
  endtask

  typedef struct {
    logic f, l0, l;
    logic re;
    logic [3:0] addr;
    logic en;
    logic [3:0] data;
    logic bsy;
    logic dn;
  } vec_t;

  vec_t tv[9];

  initial begin
    int t0, n, nlb;
    tv[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0};
    tv[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 4'd0, 1'b1, 1'b0};
    tv[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 1'b0};
    tv[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 4'd1, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0};
    tv[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 4'd3, 1'b1, 1'b0};
    tv[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0};

    repeat (3) step(0, 0, 0);
    chk_zero("reset");
    rst = 1'b0;
    step(0, 0, 0);
    clr_log();

    // latency table, which also opens the frame sweep
    t0 = 0;
    for (int i = 0; i < 9; i++) begin
      if (i == 1) t0 = cyc;
      chk($sformatf("vec%0d fb_re", i), 32'(fb_re), 32'(tv[i].re));
      if (tv[i].re)
        chk($sformatf("vec%0d fb_addr", i), 32'(fb_addr), 32'(tv[i].addr));
      chk($sformatf("vec%0d lb_en", i), 32'(lb_en), 32'(tv[i].en));
      if (tv[i].en)
        chk($sformatf("vec%0d lb_data", i), 32'(lb_data), 32'(tv[i].data));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tv[i].bsy));
      chk($sformatf("vec%0d done", i), 32'(done), 32'(tv[i].dn));
      step(tv[i].f, tv[i].l0, tv[i].l);
    end

    while (cyc - t0 < 100) step(0, 0, ((cyc - t0) % 20) == 0);

    chk("sweep lb count", 32'(lbq.size()), 12);
    if (lbq.size() == 12)
      for (int i = 0; i < 12; i++)
        chk($sformatf("sweep lb_data[%0d]", i), 32'(lbq[i]), 32'(i));
    chk("sweep fetch count", 32'(rise_cyc.size()), 3);
    if (rise_cyc.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("sweep start%0d cyc", i), 32'(rise_cyc[i] - t0),
            32'(1 + 40 * i));
        chk($sformatf("sweep start%0d addr", i), 32'(rise_addr[i]),
            32'(4 * i));
      end
    chk("sweep done count", 32'(done_n), 1);
    chk("sweep done after last lb_en", 32'(done_at - last_en), 1);
    chk("sweep overrun count", 32'(ovr_n), 0);
    chk("sweep busy end", 32'(busy), 0);

    // lines three cycles apart
    clr_log();
    step(1, 0, 0);
    t0 = cyc;
    step(0, 1, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("ovr pulse", 32'(overrun), 1);
    chk("ovr reads stopped", 32'(fb_re), 0);
    step(0, 0, 0);
    chk("ovr single pulse", 32'(overrun), 0);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (15) step(0, 0, 0);
    chk("ovr count", 32'(ovr_n), 1);
    chk("ovr lb count ok", 32'(lbq.size() >= 5 && lbq.size() <= 6), 1);
    if (lbq.size() >= 4)
      for (int i = 0; i < 4; i++)
        chk($sformatf("ovr next row data%0d", i),
            32'(lbq[lbq.size() - 4 + i]), 32'(4 + i));
    chk("ovr fetch count", 32'(rise_addr.size()), 2);
    if (rise_addr.size() == 2) begin
      chk("ovr next addr", 32'(rise_addr[1]), 4);
      chk("ovr next cyc", 32'(rise_cyc[1] - t0), 7);
    end

    // frame together with line while fetching row 2
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    chk("prio row2 fb_re", 32'(fb_re), 1);
    chk("prio row2 addr", 32'(fb_addr), 8);
    step(0, 0, 0);
    chk("prio row2 addr+1", 32'(fb_addr), 9);
    step(1, 0, 1);
    chk("prio reads stop", 32'(fb_re), 0);
    chk("prio busy armed", 32'(busy), 1);
    n = re_n;
    repeat (3) begin
      step(0, 0, 1);
      step(0, 0, 0);
    end
    chk("prio armed ignores line", 32'(re_n - n), 0);
    step(0, 1, 1);
    chk("prio refetch fb_re", 32'(fb_re), 1);
    chk("prio refetch addr", 32'(fb_addr), 0);
    step(0, 0, 0);
    chk("prio second addr", 32'(fb_addr), 1);

    // reset on the second read of a row
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    chk_zero("midrst");
    nlb = lbq.size();
    n = re_n;
    repeat (6) step(0, 0, 0);
    chk("midrst no lb_en", 32'(lbq.size() - nlb), 0);
    chk("midrst no fb_re", 32'(re_n - n), 0);

    // line activity with no frame
    step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    chk("idle no fb_re", 32'(re_n - n), 0);
    chk("idle busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
